// File: rtl/irq_controller.sv
// Priority interrupt controller: pending/mask registers, fixed-priority arbitration, IDLE/REQUEST/SERVICE handshake.
// Optional: define IRQ_EDGE_DETECT_EN for rising-edge detection (default is level-sensitive).
module irq_controller #(
    parameter int          NUM_SRC     = 4,
    parameter logic [15:0] VECTOR_BASE = 16'h0010
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               cfg_we,
    input  logic [15:0]        cfg_wdata,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic               IRQ,
    output logic [15:0]        irq_vector,
    output logic [2:0]         irq_id,
    output logic               in_service,
    output logic [NUM_SRC-1:0] mask
);

    typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] pending, detect, eligible, ack_clr;
    logic [2:0]         win_id;
    logic               win_vld;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata[15:NUM_SRC];

`ifdef IRQ_EDGE_DETECT_EN
    logic [NUM_SRC-1:0] src_q;

    // History resets to 0 so a line already high at reset release counts as an edge.
    always_ff @(posedge clock) begin
        if (reset) src_q <= '0;
        else       src_q <= irq_src;
    end

    assign detect = irq_src & ~src_q;
`else
    assign detect = irq_src;
`endif

    assign eligible = pending & mask;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        win_id  = '0;
        win_vld = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id  = 3'(i);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++)
            ack_clr[i] = (state == REQUEST) && irq_ack && (irq_id == 3'(i));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld)  state_nxt = REQUEST;
            REQUEST: if (irq_ack)  state_nxt = SERVICE;
            SERVICE: if (irq_done) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= '0;
            mask       <= '0;
            irq_id     <= '0;
            irq_vector <= VECTOR_BASE;
        end else begin
            state   <= state_nxt;
            // A new detection on the acked source survives the clear.
            pending <= (pending & ~ack_clr) | detect;
            if (cfg_we)
                mask <= cfg_wdata[NUM_SRC-1:0];
            // id/vector are only captured on IDLE->REQUEST, so they hold through the transaction.
            if (state == IDLE && win_vld) begin
                irq_id     <= win_id;
                irq_vector <= VECTOR_BASE + {12'd0, win_id, 1'b0};
            end
        end
    end

    assign IRQ        = (state == REQUEST);
    assign in_service = (state == SERVICE);

endmodule
